mux_scan_acc: RTL

MUX_SCAN_ACC -- requirements
Module: mux_scan_acc

---
 rtl/mux_scan_acc.sv | 115 +++++++++++
 1 files changed

// File: rtl/mux_scan_acc.sv
// mux_scan_acc: steps a downstream N_IN:1 multiplexer through every input,
// accumulates the returned words and, optionally, tracks the largest one.
// Optional feature macro: MUX_SCAN_MAX_EN (max/index tracking; default off,
// in which case oMAX and oMAX_IDX are tied to zero).
module mux_scan_acc #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned N_IN   = 9,
  parameter int unsigned SEL_W  = 4
) (
  input  logic                iCLK,
  input  logic                iRST,
  input  logic                iSTART,
  input  logic [DATA_W-1:0]   iQ,
  output logic [SEL_W-1:0]    oSEL,
  output logic                oBUSY,
  output logic                oDONE,
  output logic [DATA_W+3:0]   oSUM,
  output logic [DATA_W-1:0]   oMAX,
  output logic [SEL_W-1:0]    oMAX_IDX
);

  localparam int unsigned      SUM_W    = DATA_W + 4;
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(N_IN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } stateT;

  stateT            state;
  stateT            nextState;
  logic [SUM_W-1:0] acc;
  logic [SUM_W-1:0] accNext;
  logic             lastWord;

  // Running sum including the word currently presented on iQ.
  assign accNext  = acc + SUM_W'(iQ);
  assign lastWord = (state == SCAN) && (oSEL == LAST_SEL);

  // State register.
  always_ff @(posedge iCLK) begin
    if (iRST) state <= IDLE;
    else      state <= nextState;
  end

  // Next-state logic; iSTART only matters outside SCAN.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (iSTART) nextState = SCAN;
      SCAN:    if (oSEL == LAST_SEL) nextState = DONE;
      DONE:    nextState = iSTART ? SCAN : IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Select stepping, status flags, accumulator and published sum.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      oSEL  <= '0;
      oBUSY <= 1'b0;
      oDONE <= 1'b0;
      acc   <= '0;
      oSUM  <= '0;
    end else begin
      oBUSY <= (nextState == SCAN);
      oDONE <= lastWord;
      if (state == SCAN && !lastWord) oSEL <= oSEL + SEL_W'(1);
      else                            oSEL <= '0;
      // Accumulator is zero whenever a scan is about to begin.
      if (state == SCAN) acc <= accNext;
      else               acc <= '0;
      if (lastWord) oSUM <= accNext;
    end
  end

`ifdef MUX_SCAN_MAX_EN
  logic [DATA_W-1:0] maxReg;
  logic [SEL_W-1:0]  maxIdxReg;
  logic              newMax;

  // Strictly-greater compare keeps the lowest index on ties.
  assign newMax = (iQ > maxReg);

  // Running max during SCAN, published together with the sum.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      maxReg    <= '0;
      maxIdxReg <= '0;
      oMAX      <= '0;
      oMAX_IDX  <= '0;
    end else begin
      if (state == SCAN) begin
        if (newMax) begin
          maxReg    <= iQ;
          maxIdxReg <= oSEL;
        end
      end else begin
        maxReg    <= '0;
        maxIdxReg <= '0;
      end
      if (lastWord) begin
        oMAX     <= newMax ? iQ   : maxReg;
        oMAX_IDX <= newMax ? oSEL : maxIdxReg;
      end
    end
  end
`else
  // Max tracking compiled out.
  assign oMAX     = '0;
  assign oMAX_IDX = '0;
`endif

endmodule
